// File: rtl/cache_tg_pkg.sv
// Shared types for the cache traffic generator: modes, FSM states,
// LFSR polynomial, default seed and the LFSR step function.
package cache_tg_pkg;

  typedef enum logic [1:0] {
    MODE_RAND   = 2'd0,
    MODE_LOC    = 2'd1,
    MODE_STRIDE = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ISSUE,
    DRAIN,
    FIN
  } state_t;

  // Right-shift Galois form of x^32+x^22+x^2+x+1
  localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/cache_tg_lfsr.sv
// 32-bit Galois LFSR; loads SEED on reset (zero seed becomes 1).
// Ports: clk, rst_n, step (advance), value (current), nxt (stepped value).
module cache_tg_lfsr
  import cache_tg_pkg::*;
#(
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  output logic [31:0] value,
  output logic [31:0] nxt
);

  localparam logic [31:0] INIT =
    (SEED == 32'd0) ? 32'd1 : SEED;

  assign nxt = lfsr_step(value);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= INIT;
    end else if (step) begin
      value <= nxt;
    end
  end

endmodule

// File: rtl/cache_traffic_gen.sv
// Traffic generator + statistics for the cache CPU port.
// Ports: run config in, cpu_* strobes/addr/data out, cache_hit/
// cache_miss/done_signal in, busy/finished/error/counters out.
// Macro CACHE_TRAFFIC_GEN_TIMEOUT_EN enables a per-access watchdog.
module cache_traffic_gen
  import cache_tg_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 512,
  parameter int          CNT_W       = 32,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468,
  parameter int          TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_accesses,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] region_mask,
  input  logic [ADDR_W-1:0] stride,
  input  logic [6:0]        write_pct,
  output logic              cpu_read,
  output logic              cpu_write,
  output logic [ADDR_W-1:0] cpu_address,
  output logic [DATA_W-1:0] cpu_write_data,
  input  logic              cache_hit,
  input  logic              cache_miss,
  input  logic              done_signal,
  output logic              busy,
  output logic              finished,
  output logic              error,
  output logic [CNT_W-1:0]  access_count,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int NW = DATA_W / 32;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LIM =
    TW'(TIMEOUT_CYC - 1);

`ifdef CACHE_TRAFFIC_GEN_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  state_t state, state_n;

  logic [CNT_W-1:0]  n_l;
  mode_t             mode_l;
  logic [ADDR_W-1:0] base_l;
  logic [ADDR_W-1:0] mask_l;
  logic [ADDR_W-1:0] stride_l;
  logic [6:0]        pct_l;

  logic [ADDR_W-1:0] off;
  logic              is_wr;
  logic              resp_seen;
  logic [TW-1:0]     tcnt;

  logic [31:0]       lfsr_val;
  logic [31:0]       lfsr_nx;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] data_c;
  logic              wr_c;
  logic [16:0]       prod;
  logic [CNT_W-1:0]  acc_inc;
  logic              tmo_hit;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  cache_tg_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (state == SETUP),
    .value (lfsr_val),
    .nxt   (lfsr_nx)
  );

  // Access parameters come from the value the LFSR steps to in SETUP.
  // Write test: floor(p*100/1024) < pct  <=>  p*100 < pct*1024.
  always_comb begin
    addr_c = lfsr_nx[ADDR_W-1:0];
    unique case (mode_l)
      MODE_LOC:
        addr_c = base_l + (lfsr_nx[ADDR_W-1:0] & mask_l);
      MODE_STRIDE:
        addr_c = base_l + off;
      default:
        addr_c = lfsr_nx[ADDR_W-1:0];
    endcase
    prod = 17'(lfsr_nx[9:0]) * 17'd100;
    wr_c = prod < {pct_l, 10'b0};
    data_c = '0;
    for (int i = 0; i < NW; i++) begin
      data_c[i*32 +: 32] = lfsr_nx ^ 32'(i);
    end
  end

  assign acc_inc = sat_inc(access_count);
  assign tmo_hit = TMO_EN && (tcnt == TMO_LIM);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = (num_accesses == '0) ? FIN : SETUP;
        end
      end
      SETUP: state_n = ISSUE;
      ISSUE: begin
        if (done_signal) begin
          state_n = DRAIN;
        end else if (tmo_hit) begin
          state_n = FIN;
        end
      end
      DRAIN: state_n = (acc_inc == n_l) ? FIN : SETUP;
      FIN:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  assign cpu_read  = (state == ISSUE) && !is_wr;
  assign cpu_write = (state == ISSUE) && is_wr;
  assign busy      = (state == SETUP) ||
                     (state == ISSUE) ||
                     (state == DRAIN);
  assign finished  = (state == FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_l            <= '0;
      mode_l         <= MODE_RAND;
      base_l         <= '0;
      mask_l         <= '0;
      stride_l       <= '0;
      pct_l          <= '0;
      off            <= '0;
      is_wr          <= 1'b0;
      resp_seen      <= 1'b0;
      tcnt           <= '0;
      cpu_address    <= '0;
      cpu_write_data <= '0;
      error          <= 1'b0;
      access_count   <= '0;
      hit_count      <= '0;
      miss_count     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            n_l          <= num_accesses;
            mode_l       <= mode_t'(mode);
            base_l       <= base_addr;
            mask_l       <= region_mask;
            stride_l     <= stride;
            pct_l        <= write_pct;
            off          <= '0;
            error        <= 1'b0;
            access_count <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
          end
        end
        SETUP: begin
          cpu_address    <= addr_c;
          cpu_write_data <= data_c;
          is_wr          <= wr_c;
          resp_seen      <= 1'b0;
          tcnt           <= '0;
        end
        ISSUE: begin
          tcnt <= tcnt + 1'b1;
          if (!resp_seen && (cache_hit || cache_miss)) begin
            resp_seen <= 1'b1;
            // A simultaneous hit and miss is a protocol fault;
            // it is tallied as a miss.
            if (cache_miss) begin
              miss_count <= sat_inc(miss_count);
            end else begin
              hit_count <= sat_inc(hit_count);
            end
            if (cache_hit && cache_miss) begin
              error <= 1'b1;
            end
          end
          if (!done_signal && tmo_hit) begin
            error <= 1'b1;
          end
        end
        DRAIN: begin
          access_count <= acc_inc;
          off          <= (off + stride_l) & mask_l;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_traffic_gen.sv
// Scoreboard bench for cache_traffic_gen: randomized runs vs a model.
// Model produces expected accesses; monitor pops and compares.
module tb_cache_traffic_gen;

  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [31:0]  num_accesses;
  logic [1:0]   mode;
  logic [31:0]  base_addr;
  logic [31:0]  region_mask;
  logic [31:0]  stride;
  logic [6:0]   write_pct;
  logic         cpu_read;
  logic         cpu_write;
  logic [31:0]  cpu_address;
  logic [511:0] cpu_write_data;
  logic         cache_hit;
  logic         cache_miss;
  logic         done_signal;
  logic         busy;
  logic         finished;
  logic         error;
  logic [31:0]  access_count;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  cache_traffic_gen #(
    .TIMEOUT_CYC (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .num_accesses   (num_accesses),
    .mode           (mode),
    .base_addr      (base_addr),
    .region_mask    (region_mask),
    .stride         (stride),
    .write_pct      (write_pct),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .cpu_address    (cpu_address),
    .cpu_write_data (cpu_write_data),
    .cache_hit      (cache_hit),
    .cache_miss     (cache_miss),
    .done_signal    (done_signal),
    .busy           (busy),
    .finished       (finished),
    .error          (error),
    .access_count   (access_count),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic         wr;
    logic [511:0] data;
  } acc_t;

  acc_t        exp_q[$];
  logic [31:0] seen_addr[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] m_lfsr = SEED;
  logic [31:0] m_off;
  int          exp_acc;
  int          t_hit, t_miss;
  bit          t_err;
  int          resp_mode = 0;
  int          both_at = -1;
  int          resp_idx;
  bit          run_done;
  bit          tmo_expect = 0;
  int          seen_wr;
  int          strobe_cycles;

  task automatic chk(string nm, logic [511:0] a, logic [511:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // Galois LFSR for x^32+x^22+x^2+x+1, shifting right
  function automatic logic [31:0] lfsr_nx(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ ((32'd1 << 31) | (32'd1 << 21) | 32'd3);
    return r;
  endfunction

  task automatic plan(int n, int md, logic [31:0] base,
                      logic [31:0] mask, logic [31:0] strd, int pct);
    acc_t a;
    m_off = 0;
    for (int k = 0; k < n; k++) begin
      m_lfsr = lfsr_nx(m_lfsr);
      if (md == 1) a.addr = base + (m_lfsr & mask);
      else if (md == 2) a.addr = base + m_off;
      else a.addr = m_lfsr;
      a.wr = ((int'(m_lfsr % 1024) * 100) / 1024) < pct;
      for (int w = 0; w < 16; w++) a.data[w*32 +: 32] = m_lfsr ^ w;
      exp_q.push_back(a);
      if (md == 2) m_off = (m_off + strd) & mask;
    end
  endtask

  task automatic run(int n, int md, logic [31:0] base,
                     logic [31:0] mask, logic [31:0] strd, int pct);
    @(negedge clk);
    num_accesses = n;
    mode = md[1:0];
    base_addr = base;
    region_mask = mask;
    stride = strd;
    write_pct = pct[6:0];
    plan(n, md, base, mask, strd, pct);
    exp_acc = n;
    t_hit = 0;
    t_miss = 0;
    t_err = 0;
    if (tmo_expect) begin
      exp_acc = 0;
      t_err = 1;
    end
    resp_idx = 0;
    run_done = 0;
    seen_wr = 0;
    strobe_cycles = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    if (n > 0) begin
      chk("setup_busy", busy, 1);
      chk("setup_strobe", cpu_read | cpu_write, 0);
    end else begin
      chk("zero_fin", finished, 1);
      chk("zero_busy", busy, 0);
    end
    for (int c = 0; c < 20000 && !run_done; c++) begin
      @(negedge clk);
      start = (c == 6) && busy;
    end
    start = 0;
    if (!run_done) begin
      n_fail++;
      $display("FAIL run_timeout: got no finished expected finished");
    end
  endtask

  // Cache model: responds after 0..3 cycles, optionally in two steps
  int lat;
  bit served, pend, ph_h, ph_m;
  initial begin
    cache_hit = 0;
    cache_miss = 0;
    done_signal = 0;
    served = 0;
    pend = 0;
    lat = 0;
    forever begin
      @(negedge clk);
      cache_hit = 0;
      cache_miss = 0;
      done_signal = 0;
      if (!rst_n || !(cpu_read || cpu_write)) begin
        served = 0;
        pend = 0;
        lat = $urandom_range(0, 3);
      end else if (pend) begin
        cache_hit = ph_h;
        cache_miss = ph_m;
        done_signal = 1;
        pend = 0;
        served = 1;
      end else if (!served && resp_mode != 2) begin
        if (lat > 0) lat--;
        else begin
          if (resp_idx == both_at) begin
            ph_h = 1; ph_m = 1; t_miss++; t_err = 1;
          end else if (resp_mode == 0 || $urandom_range(0, 1) == 1) begin
            ph_h = 1; ph_m = 0; t_hit++;
          end else begin
            ph_h = 0; ph_m = 1; t_miss++;
          end
          resp_idx++;
          cache_hit = ph_h;
          cache_miss = ph_m;
          if (resp_mode == 1 && $urandom_range(0, 1) == 1) pend = 1;
          else begin
            done_signal = 1;
            served = 1;
          end
        end
      end
    end
  end

  // Monitor: pops expected access on each strobe rise
  bit prev_s = 0;
  initial begin
    acc_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_s = 0;
      end else begin
        if (busy || finished) chk("busy_fin", busy & finished, 0);
        if (cpu_read || cpu_write) strobe_cycles++;
        if ((cpu_read || cpu_write) && !prev_s) begin
          chk("one_strobe", cpu_read & cpu_write, 0);
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL extra_access: got %0h expected none", cpu_address);
          end else begin
            e = exp_q.pop_front();
            chk("addr", cpu_address, e.addr);
            chk("wr", cpu_write, e.wr);
            if (e.wr) chk("wdata", cpu_write_data, e.data);
            seen_addr.push_back(cpu_address);
            if (cpu_write) seen_wr++;
          end
        end
        prev_s = cpu_read | cpu_write;
        if (finished) begin
          chk("acc_cnt", access_count, exp_acc);
          chk("hit_cnt", hit_count, t_hit);
          chk("miss_cnt", miss_count, t_miss);
          chk("err", error, t_err);
          chk("q_left", exp_q.size(), 0);
          run_done = 1;
        end
      end
    end
  end

  task automatic chk_zero(string tag);
    chk({tag, "_rd"}, cpu_read, 0);
    chk({tag, "_wr"}, cpu_write, 0);
    chk({tag, "_addr"}, cpu_address, 0);
    chk({tag, "_data"}, cpu_write_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fin"}, finished, 0);
    chk({tag, "_err"}, error, 0);
    chk({tag, "_acc"}, access_count, 0);
    chk({tag, "_hit"}, hit_count, 0);
    chk({tag, "_miss"}, miss_count, 0);
  endtask

  initial begin
    logic [31:0] sl[6];
    int bad;
    int k;
    sl = '{32'h100, 32'h140, 32'h180, 32'h1C0, 32'h100, 32'h140};
    rst_n = 0;
    start = 0;
    num_accesses = 0;
    mode = 0;
    base_addr = 0;
    region_mask = 0;
    stride = 0;
    write_pct = 0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst_n = 1;
    @(negedge clk);
    chk_zero("post_rst");

    // strided window wrap
    resp_mode = 1;
    seen_addr.delete();
    run(6, 2, 32'h100, 32'hFF, 32'h40, 50);
    chk("stride_n", seen_addr.size(), 6);
    for (int i = 0; i < 6 && i < seen_addr.size(); i++)
      chk("stride_addr", seen_addr[i], sl[i]);

    // locality window, always hit, ~30% writes
    resp_mode = 0;
    seen_addr.delete();
    run(1000, 1, 32'h1000_0000, 32'hFFFF, 0, 30);
    bad = 0;
    foreach (seen_addr[i])
      if (seen_addr[i] < 32'h1000_0000 || seen_addr[i] > 32'h1000_FFFF)
        bad++;
    chk("win_viol", bad, 0);
    chk("wr_ratio", (seen_wr >= 200 && seen_wr <= 400), 1);

    // zero-length run
    run(0, 0, 0, 0, 0, 50);

    // hit+miss together once in 10
    resp_mode = 1;
    both_at = 4;
    run(10, 0, 0, 0, 0, 50);
    both_at = -1;

    // write_pct extremes and random configurations
    run(8, 0, 0, 0, 0, 0);
    chk("pct0_wr", seen_wr, 0);
    run(8, 3, 0, 0, 0, 120);
    chk("pct120_wr", seen_wr, 8);
    run(8, 1, 32'h4000, 32'hFF, 0, 100);
    chk("pct100_wr", seen_wr, 8);
    for (int r = 0; r < 8; r++) begin
      k = $urandom_range(4, 16);
      both_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
      run($urandom_range(1, 20), $urandom_range(0, 3), $urandom,
          (32'd1 << k) - 1, $urandom, $urandom_range(0, 127));
    end
    both_at = -1;

    // reset mid-ISSUE
    resp_mode = 2;
    @(negedge clk);
    num_accesses = 5;
    mode = 0;
    write_pct = 50;
    plan(5, 0, 0, 0, 0, 50);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    chk("pre_rst_strobe", cpu_read | cpu_write, 1);
    rst_n = 0;
    #1;
    chk_zero("mid_rst");
    exp_q.delete();
    m_lfsr = SEED;
    @(negedge clk);
    rst_n = 1;
    resp_mode = 1;
    run(5, 0, 0, 0, 0, 50);

`ifdef CACHE_TRAFFIC_GEN_TIMEOUT_EN
    resp_mode = 2;
    tmo_expect = 1;
    run(1, 0, 0, 0, 0, 50);
    chk("tmo_cycles", strobe_cycles, 16);
    tmo_expect = 0;
    resp_mode = 1;
    run(3, 0, 0, 0, 0, 50);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_traffic_gen.md
# cache_traffic_gen

Synthesizable, parametrised traffic generator and statistics unit that drives the CPU-side request port of the cache controller (`top_level`). It issues programmable sequences of read/write accesses in random, locality-window or strided patterns, performs the same request/done handshake the cache expects, and accumulates hit, miss and access counts. It sits beside the cache in on-chip self-test builds and replaces software stimulus for long hit-rate characterisation runs.

## Interface
- ADDR_W, 32, request address width
- DATA_W, 512, write-data width; multiple of 32
- CNT_W, 32, width of access and statistics counters
- LFSR_SEED, 32'hACE1_2468, reset seed; a zero value is replaced by 1
- TIMEOUT_CYC, 4096, watchdog limit per access (used only under the macro)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle run request; sampled only in IDLE
- num_accesses  in  CNT_W  accesses per run
- mode  in  2  0 random, 1 locality, 2 stride, 3 reserved (treated as 0)
- base_addr  in  ADDR_W  window base for modes 1/2
- region_mask  in  ADDR_W  window offset mask (power-of-two window minus 1)
- stride  in  ADDR_W  mode-2 offset increment
- write_pct  in  7  write percentage, 0..100; values >100 act as 100
- cpu_read, cpu_write  out  1 each  request strobes to cache
- cpu_address  out  ADDR_W  request address
- cpu_write_data  out  DATA_W  write payload
- cache_hit, cache_miss, done_signal  in  1 each  cache response
- busy  out  1  run in progress
- finished  out  1  one-cycle pulse at run end
- error  out  1  sticky protocol/timeout flag, cleared by start
- access_count, hit_count, miss_count  out  CNT_W each  statistics

## Operation
- FSM: IDLE, SETUP, ISSUE, DRAIN, FIN.
- IDLE: start=1 clears counters and error, latches all configuration inputs; num_accesses=0 -> FIN, else SETUP.
- SETUP (1 cycle): LFSR steps once; cpu_address/cpu_write_data loaded; both strobes low; read/write choice latched.
- ISSUE: selected strobe high and held; address/data stable. First cycle with cache_hit|cache_miss increments exactly one of hit_count/miss_count per access; both high together -> miss counted, error set. done_signal high -> DRAIN.
- DRAIN (1 cycle): strobes low; access_count++; if access_count==num_accesses -> FIN else SETUP.
- FIN (1 cycle): finished=1; -> IDLE.
- LFSR: 32-bit Galois, taps x^32+x^22+x^2+x+1, never zero.
- Address: mode 0 = lfsr[ADDR_W-1:0]; mode 1 = base_addr + (lfsr & region_mask); mode 2 = base_addr + off, off starts 0, off <= (off+stride) & region_mask after each access (wraps within window). Sum truncated to ADDR_W.
- Write decision: sample = (lfsr[9:0]*100)>>10 (0..99); write when sample < write_pct. write_pct=0 never writes; 100 always writes.
- Write data: 32-bit word i = lfsr ^ i.
- Counters saturate at all-ones; no wrap.

## Timing
- Reset: all outputs 0, FSM IDLE, LFSR=seed, off=0.
- start at edge N -> SETUP during N+1 -> strobe high from N+2.
- Strobe drops the cycle after done_signal sampled high; minimum access period 3 cycles (SETUP, ISSUE, DRAIN).
- start outside IDLE ignored. Reset mid-run aborts immediately; no finished pulse.
- finished and busy never high together; busy high from SETUP through DRAIN.

## Configuration
- CACHE_TRAFFIC_GEN_TIMEOUT_EN defined: cycle counter in ISSUE; reaching TIMEOUT_CYC without done_signal sets error, drops strobe, goes to FIN (access not counted).
- Undefined: no watchdog; ISSUE waits indefinitely.

## Structure
- Package cache_tg_pkg: mode encodings, FSM state enum, LFSR polynomial constant, default seed.
- One sub-module: cache_tg_lfsr (32-bit Galois LFSR, seed load, step enable).

## Test plan
- Reset: rst_n low mid-ISSUE -> all outputs 0 immediately; next start behaves as fresh run.
- Mode 1, base 0x1000_0000, mask 0xFFFF, 1000 accesses, write_pct 30, cache model always hits -> every address in [0x1000_0000,0x1000_FFFF], hit_count=1000, miss_count=0, writes ≈30%.
- Mode 2, base 0x100, stride 0x40, mask 0xFF, 6 accesses -> addresses 0x100,0x140,0x180,0x1C0,0x100,0x140.
- num_accesses=0 -> finished one cycle after start-edge+1, counters 0, no strobes.
- hit and miss asserted together once in 10 accesses -> miss_count includes it, error=1, access_count=10.
- With macro, TIMEOUT_CYC=16, done_signal never returns -> strobe drops after 16 ISSUE cycles, error=1, finished pulse, access_count=0.
